// File: rtl/array_pkg.sv
// Shared constants and types for the systolic MAC array edge logic.
// Used by the pe_v2 tiles, the north-edge feeder and the west-edge skew feeder.
//   Q_WIDTH           : operand width of one Q4.4 lane word
//   Q_FRAC            : number of fractional bits in a Q4.4 word
//   DEFAULT_NUM_LANES : default number of PE rows fed from the west edge
//   feeder_state_e    : feeder FSM encoding (IDLE, STREAM, FLUSH)
package array_pkg;

  localparam int Q_WIDTH           = 8;
  localparam int Q_FRAC            = 4;
  localparam int DEFAULT_NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Valid+data shift register of DEPTH stages with asynchronous clear.
// One instance per lane gives that lane its diagonal skew.
// Ports:
//   clk, rst_n : clock, asynchronous active-low clear of every stage
//   in_valid   : valid bit entering stage 0
//   in_data    : data word entering stage 0
//   out_valid  : valid bit leaving the last stage (DEPTH cycles later)
//   out_data   : data word leaving the last stage
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_sr;
  logic [WIDTH-1:0] dat_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) dat_sr[i] <= '0;
    end else begin
      vld_sr[0] <= in_valid;
      dat_sr[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        dat_sr[i] <= dat_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[DEPTH-1];
  assign out_data  = dat_sr[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// West-edge feeder for the systolic MAC array. Takes one packed column of
// Q4.4 operands per beat and delays lane i by i cycles so the rows receive
// a diagonal wavefront. Idle cycles inject zero words with valid low.
// Handshake: a beat transfers on a rising edge where s_valid && s_ready;
// s_data/s_last are only looked at on such an edge, s_ready does not depend
// combinationally on s_valid, and s_ready is low while the skew pipe drains.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   s_data      : packed column, lane i = s_data[i*WIDTH +: WIDTH]
//   s_valid     : beat valid
//   s_last      : final beat of a tile (qualified by s_valid)
//   s_ready     : feeder accepts a beat
//   west_data   : skewed operands, lane i drives PE row i
//   west_valid  : per-lane valid, high only for real beats
//   tile_start  : pulse when the first beat of a tile is on lane 0
//   tile_done   : pulse when the last beat of a tile is on lane NUM_LANES-1
//   busy        : FSM in STREAM or FLUSH
//   tile_len    : beats accepted in the current/most recent tile (saturating)
//   fsm_state   : current FSM state, for debug and checkers
module systolic_skew_feeder
  import array_pkg::*;
#(
  parameter int NUM_LANES = DEFAULT_NUM_LANES,
  parameter int WIDTH     = Q_WIDTH,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_LANES*WIDTH-1:0] s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [NUM_LANES*WIDTH-1:0] west_data,
  output logic [NUM_LANES-1:0]     west_valid,
  output logic                     tile_start,
  output logic                     tile_done,
  output logic                     busy,
  output logic [CNT_W-1:0]         tile_len,
  output feeder_state_e            fsm_state
);

  localparam int FC_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  feeder_state_e   state;
  logic [FC_W-1:0] flush_cnt;
  logic            accept;
  logic            last_vld;
  logic            last_dat;

  assign accept    = s_valid && s_ready;
  assign fsm_state = state;

  // Per-lane skew: lane i has i+1 register stages. Words are zeroed when no
  // beat is accepted so bubbles contribute nothing to the MACs.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [WIDTH-1:0] lane_in;
    assign lane_in = accept ? s_data[i*WIDTH +: WIDTH] : '0;

    skew_delay_line #(
      .DEPTH (i + 1),
      .WIDTH (WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept),
      .in_data   (lane_in),
      .out_valid (west_valid[i]),
      .out_data  (west_data[i*WIDTH +: WIDTH])
    );
  end

  // The s_last flag travels alongside the bottom lane, so tile_done lines up
  // exactly with the last beat on row NUM_LANES-1 and is wiped by reset.
  skew_delay_line #(
    .DEPTH (NUM_LANES),
    .WIDTH (1)
  ) u_last (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_data   (s_last),
    .out_valid (last_vld),
    .out_data  (last_dat)
  );

  assign tile_done = last_vld && last_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      flush_cnt  <= '0;
      tile_len   <= '0;
      tile_start <= 1'b0;
    end else begin
      tile_start <= accept && (state == IDLE);
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (state == IDLE) begin
              tile_len <= CNT_W'(1);
            end else if (tile_len != {CNT_W{1'b1}}) begin
              tile_len <= tile_len + CNT_W'(1);
            end
            if (s_last) begin
              if (NUM_LANES > 1) begin
                state     <= FLUSH;
                s_ready   <= 1'b0;
                busy      <= 1'b1;
                flush_cnt <= FC_W'(NUM_LANES - 1);
              end else begin
                // A single lane has nothing to drain.
                state   <= IDLE;
                s_ready <= 1'b1;
                busy    <= 1'b0;
              end
            end else begin
              state   <= STREAM;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end
          end else begin
            // Also raises s_ready on the first edge after reset release.
            s_ready <= 1'b1;
            busy    <= (state == STREAM);
          end
        end
        FLUSH: begin
          // The counter reaches 0 in the tile_done cycle; leave on that edge.
          if (flush_cnt == '0) begin
            state   <= IDLE;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  import array_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (NUM_LANES=4, WIDTH=8, CNT_W=8) ----------------
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [31:0]   west_data;
  logic [3:0]    west_valid;
  logic          tile_start;
  logic          tile_done;
  logic          busy;
  logic [7:0]    tile_len;
  feeder_state_e fsm_state;

  systolic_skew_feeder #(.NUM_LANES(4), .WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .west_data  (west_data),
    .west_valid (west_valid),
    .tile_start (tile_start),
    .tile_done  (tile_done),
    .busy       (busy),
    .tile_len   (tile_len),
    .fsm_state  (fsm_state)
  );

  // ---------------- saturation DUT (CNT_W=2) ----------------
  logic [31:0]   sat_data;
  logic          sat_valid;
  logic          sat_last;
  logic          sat_ready;
  logic [31:0]   sat_wd;
  logic [3:0]    sat_wv;
  logic          sat_start;
  logic          sat_done;
  logic          sat_busy;
  logic [1:0]    sat_len;
  feeder_state_e sat_state;

  systolic_skew_feeder #(.NUM_LANES(4), .WIDTH(8), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (sat_data),
    .s_valid    (sat_valid),
    .s_last     (sat_last),
    .s_ready    (sat_ready),
    .west_data  (sat_wd),
    .west_valid (sat_wv),
    .tile_start (sat_start),
    .tile_done  (sat_done),
    .busy       (sat_busy),
    .tile_len   (sat_len),
    .fsm_state  (sat_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  // Inputs are driven before an edge; expectations are sampled 1 ns after it.
  typedef struct {
    logic          v;
    logic          last;
    logic [31:0]   data;
    logic          ready;
    logic [3:0]    wv;
    logic [31:0]   wd;
    logic          start;
    logic          done;
    logic          bsy;
    logic [7:0]    len;
    feeder_state_e st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic last, input logic [31:0] data,
                     input logic ready, input logic [3:0] wv, input logic [31:0] wd,
                     input logic start, input logic done, input logic bsy,
                     input logic [7:0] len, input feeder_state_e st);
    vec_t r;
    r.v = v; r.last = last; r.data = data; r.ready = ready; r.wv = wv; r.wd = wd;
    r.start = start; r.done = done; r.bsy = bsy; r.len = len; r.st = st;
    tbl.push_back(r);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic last, input logic [31:0] d);
    s_valid = v;
    s_last  = last;
    s_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].v, tbl[i].last, tbl[i].data);
      tick();
      chk($sformatf("r%0d_ready", i), 32'(s_ready),    32'(tbl[i].ready));
      chk($sformatf("r%0d_wv", i),    32'(west_valid), 32'(tbl[i].wv));
      chk($sformatf("r%0d_wd", i),    west_data,       tbl[i].wd);
      chk($sformatf("r%0d_start", i), 32'(tile_start), 32'(tbl[i].start));
      chk($sformatf("r%0d_done", i),  32'(tile_done),  32'(tbl[i].done));
      chk($sformatf("r%0d_busy", i),  32'(busy),       32'(tbl[i].bsy));
      chk($sformatf("r%0d_len", i),   32'(tile_len),   32'(tbl[i].len));
      chk($sformatf("r%0d_state", i), 32'(fsm_state),  32'(tbl[i].st));
    end
  endtask

  initial begin
    //  v  last data          ready wv       wd            st dn bsy len st
    // 3 continuous beats, last on the third (rows 0-6)
    add(1, 0, 32'h10203040, 1, 4'b0001, 32'h00000040, 1, 0, 1, 1, STREAM);
    add(1, 0, 32'h11213141, 1, 4'b0011, 32'h00003041, 0, 0, 1, 2, STREAM);
    add(1, 1, 32'h12223242, 0, 4'b0111, 32'h00203142, 0, 0, 1, 3, FLUSH);
    add(0, 0, 32'h0,        0, 4'b1110, 32'h10213200, 0, 0, 1, 3, FLUSH);
    add(0, 0, 32'h0,        0, 4'b1100, 32'h11220000, 0, 0, 1, 3, FLUSH);
    add(0, 0, 32'h0,        0, 4'b1000, 32'h12000000, 0, 1, 1, 3, FLUSH);
    add(0, 0, 32'h0,        1, 4'b0000, 32'h00000000, 0, 0, 0, 3, IDLE);
    // bubble between two beats; s_last with s_valid low is ignored (rows 7-13)
    add(1, 0, 32'hA3A2A1A0, 1, 4'b0001, 32'h000000A0, 1, 0, 1, 1, STREAM);
    add(0, 1, 32'hFFFFFFFF, 1, 4'b0010, 32'h0000A100, 0, 0, 1, 1, STREAM);
    add(1, 1, 32'hB3B2B1B0, 0, 4'b0101, 32'h00A200B0, 0, 0, 1, 2, FLUSH);
    add(0, 0, 32'h0,        0, 4'b1010, 32'hA300B100, 0, 0, 1, 2, FLUSH);
    add(0, 0, 32'h0,        0, 4'b0100, 32'h00B20000, 0, 0, 1, 2, FLUSH);
    add(0, 0, 32'h0,        0, 4'b1000, 32'hB3000000, 0, 1, 1, 2, FLUSH);
    add(0, 0, 32'h0,        1, 4'b0000, 32'h00000000, 0, 0, 0, 2, IDLE);
    // single-beat tile, then s_valid held through the flush (rows 14-23)
    add(1, 1, 32'h18181818, 0, 4'b0001, 32'h00000018, 1, 0, 1, 1, FLUSH);
    add(1, 0, 32'h2C2B2A29, 0, 4'b0010, 32'h00001800, 0, 0, 1, 1, FLUSH);
    add(1, 0, 32'h2C2B2A29, 0, 4'b0100, 32'h00180000, 0, 0, 1, 1, FLUSH);
    add(1, 0, 32'h2C2B2A29, 0, 4'b1000, 32'h18000000, 0, 1, 1, 1, FLUSH);
    add(1, 0, 32'h2C2B2A29, 1, 4'b0000, 32'h00000000, 0, 0, 0, 1, IDLE);
    add(1, 1, 32'h2C2B2A29, 0, 4'b0001, 32'h00000029, 1, 0, 1, 1, FLUSH);
    add(0, 0, 32'h0,        0, 4'b0010, 32'h00002A00, 0, 0, 1, 1, FLUSH);
    add(0, 0, 32'h0,        0, 4'b0100, 32'h002B0000, 0, 0, 1, 1, FLUSH);
    add(0, 0, 32'h0,        0, 4'b1000, 32'h2C000000, 0, 1, 1, 1, FLUSH);
    add(0, 0, 32'h0,        1, 4'b0000, 32'h00000000, 0, 0, 0, 1, IDLE);
    // fresh 2-beat tile after a mid-stream reset (rows 24-29)
    add(1, 0, 32'h0D0C0B0A, 1, 4'b0001, 32'h0000000A, 1, 0, 1, 1, STREAM);
    add(1, 1, 32'h1D1C1B1A, 0, 4'b0011, 32'h00000B1A, 0, 0, 1, 2, FLUSH);
    add(0, 0, 32'h0,        0, 4'b0110, 32'h000C1B00, 0, 0, 1, 2, FLUSH);
    add(0, 0, 32'h0,        0, 4'b1100, 32'h0D1C0000, 0, 0, 1, 2, FLUSH);
    add(0, 0, 32'h0,        0, 4'b1000, 32'h1D000000, 0, 1, 1, 2, FLUSH);
    add(0, 0, 32'h0,        1, 4'b0000, 32'h00000000, 0, 0, 0, 2, IDLE);

    // ---- reset state ----
    rst_n = 1'b0;
    drive(0, 0, 32'h0);
    sat_valid = 1'b0; sat_last = 1'b0; sat_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_ready),    32'h0);
    chk("rst_wv",    32'(west_valid), 32'h0);
    chk("rst_wd",    west_data,       32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_len",   32'(tile_len),   32'h0);
    chk("rst_state", 32'(fsm_state),  32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 32'(s_ready), 32'h1);

    run_rows(0, 23);

    // ---- async reset between edges, mid-STREAM ----
    drive(1, 0, 32'h44332211);
    tick();
    chk("mr_wv0", 32'(west_valid), 32'h1);
    drive(1, 0, 32'h55667788);
    tick();
    chk("mr_wv1", 32'(west_valid), 32'h3);
    chk("mr_busy1", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_wv",    32'(west_valid), 32'h0);
    chk("mr_wd",    west_data,       32'h0);
    chk("mr_busy",  32'(busy),       32'h0);
    chk("mr_ready", 32'(s_ready),    32'h0);
    chk("mr_state", 32'(fsm_state),  32'(IDLE));
    drive(0, 0, 32'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("mr_nodone%0d", k), 32'(tile_done),  32'h0);
      chk($sformatf("mr_idle_wv%0d", k), 32'(west_valid), 32'h0);
    end

    run_rows(24, 29);

    // ---- tile_len saturation with CNT_W=2 ----
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    for (int k = 0; k < 5; k++) begin
      sat_valid = 1'b1;
      sat_last  = (k == 4);
      sat_data  = 32'($urandom_range(0, 255));
      tick();
      chk($sformatf("sat_len%0d", k), 32'(sat_len), 32'(exp_q.pop_front()));
    end
    sat_valid = 1'b0;
    sat_last  = 1'b0;
    repeat (6) tick();
    chk("sat_hold", 32'(sat_len), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream feeder for the west edge of the systolic MAC array built from pe_v2 tiles.
- Accepts one packed column of A operands per beat over a valid/ready stream. Each beat carries NUM_LANES Q4.4 words, one per PE row.
- Lane i is delayed by i cycles, producing the diagonal wavefront the array needs.
- Inserts zero bubbles, drains the skew pipeline after the last beat of a tile, and signals tile start/done to the array controller.

Parameters:
- NUM_LANES, 4, number of PE rows fed (lane 0 = top row); must be >= 1
- WIDTH, 8, operand width per lane (Q4.4, matches pe_v2 WIDTH_A)
- CNT_W, 8, width of the beat counter reported as tile_len

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  NUM_LANES*WIDTH  packed column; lane i = s_data[i*WIDTH +: WIDTH]
- s_valid  in  1  s_data valid
- s_last  in  1  marks final beat of a tile; qualified by s_valid
- s_ready  out  1  feeder can accept a beat
- west_data  out  NUM_LANES*WIDTH  skewed operands to the PE in_west ports; lane i drives row i
- west_valid  out  NUM_LANES  per-lane valid; high only when lane carries a real beat
- tile_start  out  1  one-cycle pulse when the first beat of a tile appears on lane 0
- tile_done  out  1  one-cycle pulse when the last beat appears on lane NUM_LANES-1
- busy  out  1  high in STREAM or FLUSH
- tile_len  out  CNT_W  beats accepted in the current or most recent tile; saturates at 2^CNT_W-1

Behaviour:
- Reset (async, rst_n=0): all delay registers and outputs are 0, FSM = IDLE, counters = 0.
  - s_ready is 0 while rst_n=0 and 1 from the first clock edge after release.
  - Reset mid-tile discards all in-flight data; no tile_done is emitted.
- Accept: a beat is accepted when s_valid && s_ready at a rising edge.
- Skew pipeline: lane i is a registered delay line of depth i+1.
  - A beat accepted at edge t appears on lane i at cycle t+1+i, so lane 0 has latency 1.
  - Data passes bit-exact; no arithmetic, no width change.
- Bubbles: in a cycle with no accepted beat, a zero word with valid=0 enters lane 0's stage. The array clocks freely; zero operands add nothing to the MAC.
- FSM IDLE: s_ready=1, busy=0.
  - An accepted beat with s_last=0 goes to STREAM and sets tile_len=1.
  - An accepted beat with s_last=1 goes to FLUSH, or stays in IDLE when NUM_LANES=1.
  - tile_start pulses at t+1.
- FSM STREAM: s_ready=1, busy=1.
  - Each accepted beat increments tile_len (saturating).
  - A beat accepted with s_last=1 at edge t leads to FLUSH, or to IDLE when NUM_LANES=1.
  - s_valid low inserts a bubble; the FSM stays in STREAM.
- FSM FLUSH: s_ready=0, busy=1.
  - A down-counter loaded with NUM_LANES-1 decrements each cycle.
  - At 0 the FSM returns to IDLE, coinciding with the tile_done cycle t+NUM_LANES.
- Flush timing: s_ready is low for cycles t+1..t+NUM_LANES and returns high at t+NUM_LANES+1.
  - The next tile's first beat can be accepted at edge t+NUM_LANES+1.
- tile_done: asserted exactly in the cycle west_valid[NUM_LANES-1] carries the s_last beat.
- Single-beat tile (s_last on the first beat): tile_start at t+1, tile_done at t+NUM_LANES. With NUM_LANES=1 both pulse in the same cycle.
- tile_len: holds its value after tile_done until the next tile's first beat, which reloads it to 1.
- s_last with s_valid=0: ignored.

Decomposition:
- Shared package (array_pkg): the Q4.4 lane width and fractional width, NUM_LANES default, and the FSM state enum {IDLE, STREAM, FLUSH}. The same constants are used by pe_v2 instances and the north-edge feeder.
- One sub-module, skew_delay_line (params DEPTH, WIDTH): a valid+data shift register with async clear. It is instantiated per lane with DEPTH=i+1.
- The FSM and counters live in the top level.

Test Plan (NUM_LANES=4, WIDTH=8):
- Reset release, then 3 continuous beats {lanes 3..0}=0x10203040, 0x11213141, 0x12223242 (third with s_last). Required response:
  - lane0 emits 0x40,0x41,0x42 at t+1..t+3.
  - lane3 emits 0x10,0x11,0x12 at t+4..t+6.
  - tile_start at t+1, tile_done at t+6, tile_len=3.
- Bubble: beats at edges 0 and 2 (s_valid low at edge 1). Required response:
  - lane0 shows valid,0-with-valid=0,valid.
  - Skew is preserved on lane 3 three cycles later.
  - The FSM stays in STREAM.
- Single-beat tile 0x18181818 with s_last. Required response:
  - s_ready is 0 for 4 cycles.
  - tile_start and tile_done are 3 cycles apart.
  - A second tile is accepted on the 5th edge after the first.
- Back-to-back tiles: s_valid held high across the flush. Required response:
  - No beat is accepted while s_ready=0.
  - The second tile's data appears only after the first tile_done.
  - Lane values are uncorrupted.
- Async reset asserted mid-STREAM (between edges). Required response:
  - All west_valid/west_data go to 0 immediately; busy goes to 0.
  - No tile_done is emitted.
  - After release, a new tile streams correctly.
- Saturation at CNT_W=2: a 5-beat tile. Required response: tile_len reads 1,2,3,3,3.
